cache_ctrl: RTL and testbench
=============================

# cache_ctrl

Direct-mapped, write-through, single-word-line cache controller between the CPU datapath and the synchronous single-port RAM. It accepts one load or store at a time over a valid/ready request port. Reads hit from the tag/data arrays or fill from RAM. Stores are always written through to RAM and update the line. It provides the `found` indication and data the CPU uses in place of a direct RAM read.

## Interface
- ADDR_WIDTH, 14, word address width (matches RAM `addr`)
- DATA_WIDTH, 32, word width
- LINES, 16, number of cache lines; power of two, ≥2; IDX = log2(LINES)
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  reset; **one clock; reset is asynchronous and active-low**
- req_valid  in  1  CPU request present
- req_ready  out  1  controller can accept a request (high only in IDLE)
- req_we  in  1  1 = store, 0 = load
- req_addr  in  ADDR_WIDTH  word address
- req_wdata  in  DATA_WIDTH  store data
- inv  in  1  invalidate all lines
- rsp_valid  out  1  one-cycle response strobe
- rsp_rdata  out  DATA_WIDTH  load data; registered, held until next response
- rsp_hit  out  1  `found`: lookup hit, valid with rsp_valid
- mem_cs, mem_we, mem_oe  out  1 each  RAM controls
- mem_addr  out  ADDR_WIDTH  RAM address
- mem_wdata  out  DATA_WIDTH  RAM write data; tristate merge is done outside this block
- mem_rdata  in  DATA_WIDTH  RAM read data; valid the cycle after a read command
- hit_cnt, miss_cnt  out  16 each  load hit/miss counters

## Operation

**Address split:** index = req_addr[IDX-1:0], tag = req_addr[ADDR_WIDTH-1:IDX].

**Per-line state:** valid bit, tag, data word. Valid bits reset to 0. Tag and data arrays are not reset.

**Request capture:** a request is accepted on an edge where req_valid && req_ready. Address, we and wdata are latched at acceptance. Inputs are ignored at all other times.

**FSM states:**
- IDLE: req_ready=1. On accept, go to LOOKUP.
- LOOKUP: compute hit = valid[idx] && tag match.
  - Load hit: rsp_rdata ← line data, go to RESP.
  - Load miss: go to MEM_RD.
  - Store: go to MEM_WR.
- MEM_RD: mem_cs=1, mem_oe=1, mem_we=0, mem_addr=latched addr. Go to MEM_WAIT.
- MEM_WAIT: capture mem_rdata into rsp_rdata and into the line; set valid and tag. Go to RESP.
- MEM_WR: mem_cs=1, mem_we=1, mem_oe=0, mem_addr, mem_wdata=latched data. Write the line (valid, tag, data) on the same edge; this is write-allocate. Go to RESP.
- RESP: rsp_valid=1, rsp_hit = LOOKUP result. Go to IDLE.

**Memory outputs:** mem_cs, mem_we and mem_oe are 0 in every other state. mem_addr and mem_wdata are don't-care when mem_cs=0.

**Store responses:** rsp_valid pulses with rsp_hit reported. rsp_rdata is unchanged.

**Counters:** updated in LOOKUP for loads only. A hit increments hit_cnt, a miss increments miss_cnt. Both saturate at 16'hFFFF. Neither reset by inv.

**Invalidate:** inv clears all valid bits on any edge.
- If inv coincides with a fill or store line update, inv wins and the line ends invalid. The response is still delivered normally.
- If inv and an accepted request share an edge, the LOOKUP sees the cleared array, so the request misses.

**Response handshake:** there is no response backpressure. The CPU must take rsp_valid in the cycle it is asserted.

## Timing
- Latency counts edges from the accept edge (cycle 0) to the cycle rsp_valid is high:
  - load hit: 2
  - load miss: 4
  - store: 3
- Exactly one RAM command per miss or store; none on a hit.
- Back-to-back: the next accept is possible the cycle after RESP, so throughput is 1 request per latency+1 cycles.

**Reset values** (asynchronous, immediate on rst_n low): state IDLE, req_ready=1, rsp_valid=0, rsp_hit=0, rsp_rdata=0, mem_cs=mem_we=mem_oe=0, mem_addr=0, mem_wdata=0, hit_cnt=miss_cnt=0, all valid=0.

**Reset mid-operation:** any in-flight request is dropped and no response is issued. A RAM read in progress is abandoned. A RAM write is lost unless the reset falls after the MEM_WR edge.

## Test plan
1. **Cold read, then repeat.** Reset; RAM[0x11E]=0x78000000; load 0x11E.
   - Required: one RAM read at 0x11E; rsp_valid at +4 with rdata=0x78000000, hit=0.
   - Reload 0x11E: rsp_valid at +2, hit=1, same data, no mem_cs.
2. **Write-through store.** Store 0x120 ← 0x00000005.
   - Required: a single cycle with mem_cs=1, we=1, oe=0, addr=0x120, wdata=5; rsp_valid at +3.
   - Load 0x120: hit=1, rdata=5, RAM[0x120]=5.
3. **Index conflict** (LINES=16). Load 0x11E, load 0x12E, load 0x11E.
   - Required: all three miss; miss_cnt=3, hit_cnt=0.
4. **Invalidate with request.** With 0x11E cached, pulse inv on the same edge as an accepted load of 0x11E.
   - Required: hit=0, one RAM read, correct data; miss_cnt +1.
5. **Reset during miss.** Drive rst_n low while in MEM_WAIT for load 0x104.
   - Required: outputs at reset values immediately; no rsp_valid after release.
   - Reload 0x104: misses.
6. **Counter check.** Loads to 0x100, 0x102, 0x100, 0x102, 0x100 from cold.
   - Required: hit_cnt=3, miss_cnt=2.

Source files
------------

// File: rtl/cache_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : cache_ctrl                                                      |
// | Brief    : Direct-mapped, write-through, single-word-line cache controller |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module cache_ctrl #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 32,
    parameter int LINES      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic                  inv,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_hit,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic                  mem_oe,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [15:0]           hit_cnt,
    output logic [15:0]           miss_cnt
);
    localparam int IDX   = $clog2(LINES);
    localparam int TAG_W = ADDR_WIDTH - IDX;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LOOKUP   = 3'd1;
    localparam logic [2:0] S_MEM_RD   = 3'd2;
    localparam logic [2:0] S_MEM_WAIT = 3'd3;
    localparam logic [2:0] S_MEM_WR   = 3'd4;
    localparam logic [2:0] S_RESP     = 3'd5;

    localparam logic [15:0] c_CNT_MAX = 16'hFFFF;

    logic [2:0]            r_state;
    logic [2:0]            w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_we;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_hit;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [15:0]           r_hit_cnt;
    logic [15:0]           r_miss_cnt;
    logic [LINES-1:0]      r_valid;
    logic [TAG_W-1:0]      r_tag  [LINES];
    logic [DATA_WIDTH-1:0] r_data [LINES];

    logic [IDX-1:0]        w_idx;
    logic [TAG_W-1:0]      w_tag;
    logic                  w_hit;
    logic                  w_accept;
    logic                  w_line_wr;
    logic [DATA_WIDTH-1:0] w_line_data;

    assign w_idx       = r_addr[IDX-1:0];
    assign w_tag       = r_addr[ADDR_WIDTH-1:IDX];
    assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_accept    = req_valid && (r_state == S_IDLE);
    assign w_line_wr   = (r_state == S_MEM_WAIT) || (r_state == S_MEM_WR);
    assign w_line_data = (r_state == S_MEM_WR) ? r_wdata : mem_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:     if (req_valid) w_state_nxt = S_LOOKUP;
            S_LOOKUP:   begin
                if (r_we)       w_state_nxt = S_MEM_WR;
                else if (w_hit) w_state_nxt = S_RESP;
                else            w_state_nxt = S_MEM_RD;
            end
            S_MEM_RD:   w_state_nxt = S_MEM_WAIT;
            S_MEM_WAIT: w_state_nxt = S_RESP;
            S_MEM_WR:   w_state_nxt = S_RESP;
            S_RESP:     w_state_nxt = S_IDLE;
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_hit   = 1'b0;
        mem_cs    = 1'b0;
        mem_we    = 1'b0;
        mem_oe    = 1'b0;
        case (r_state)
            S_IDLE:   req_ready = 1'b1;
            S_MEM_RD: begin
                mem_cs = 1'b1;
                mem_oe = 1'b1;
            end
            S_MEM_WR: begin
                mem_cs = 1'b1;
                mem_we = 1'b1;
            end
            S_RESP:   begin
                rsp_valid = 1'b1;
                rsp_hit   = r_hit;
            end
            default:  ;
        endcase
    end

    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign rsp_rdata = r_rdata;
    assign hit_cnt   = r_hit_cnt;
    assign miss_cnt  = r_miss_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr     <= '0;
            r_we       <= 1'b0;
            r_wdata    <= '0;
            r_hit      <= 1'b0;
            r_rdata    <= '0;
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
            r_valid    <= '0;
        end else begin
            if (w_accept) begin
                r_addr  <= req_addr;
                r_we    <= req_we;
                r_wdata <= req_wdata;
            end
            if (r_state == S_LOOKUP) begin
                r_hit <= w_hit;
                if (!r_we) begin
                    if (w_hit) begin
                        r_rdata <= r_data[w_idx];
                        if (r_hit_cnt != c_CNT_MAX) r_hit_cnt <= r_hit_cnt + 16'd1;
                    end else if (r_miss_cnt != c_CNT_MAX) begin
                        r_miss_cnt <= r_miss_cnt + 16'd1;
                    end
                end
            end
            if (r_state == S_MEM_WAIT) r_rdata <= mem_rdata;
            // Invalidate beats a same-edge fill/store so the line ends invalid.
            if (inv)            r_valid        <= '0;
            else if (w_line_wr) r_valid[w_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_line_wr) begin
            r_tag[w_idx]  <= w_tag;
            r_data[w_idx] <= w_line_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cache_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_cache_ctrl                                                   |
// | Brief    : Vector table, corner sequences and random run against a model   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_cache_ctrl;
    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [13:0] req_addr;
    logic [31:0] req_wdata;
    logic        inv;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_hit;
    logic        mem_cs;
    logic        mem_we;
    logic        mem_oe;
    logic [13:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    cache_ctrl #(.ADDR_WIDTH(14), .DATA_WIDTH(32), .LINES(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .inv(inv),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_hit(rsp_hit),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_oe(mem_oe),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(logic [13:0] a);
        if (a == 14'h11E) return 32'h7800_0000;
        return ({18'h0, a} * 32'h0100_0193) ^ 32'hA5A5_0000;
    endfunction

    // Synchronous single-port RAM; untouched words read back their init value.
    logic [31:0] ram_w [logic [13:0]];
    function automatic logic [31:0] ram_rd(logic [13:0] a);
        return ram_w.exists(a) ? ram_w[a] : init_word(a);
    endfunction

    always @(posedge clk) begin
        if (mem_cs && mem_we) ram_w[mem_addr] = mem_wdata;
        if (mem_cs && mem_oe && !mem_we) mem_rdata <= ram_rd(mem_addr);
    end

    // Reference-side copy of RAM contents, independent of the DUT-driven RAM.
    logic [31:0] mram [logic [13:0]];
    function automatic logic [31:0] mram_rd(logic [13:0] a);
        return mram.exists(a) ? mram[a] : init_word(a);
    endfunction

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endfunction

    task automatic do_reset(input bit check);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        if (check) begin
            chk("rst_ready_valid_hit", 32'({req_ready, rsp_valid, rsp_hit}), 32'b100);
            chk("rst_mem_ctl", 32'({mem_cs, mem_we, mem_oe}), 32'b000);
            chk("rst_mem_addr", 32'(mem_addr), 32'h0);
            chk("rst_mem_wdata", mem_wdata, 32'h0);
            chk("rst_rdata", rsp_rdata, 32'h0);
            chk("rst_counters", {hit_cnt, miss_cnt}, 32'h0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Issue one request at a negedge; inv is raised during cycle inv_at
    // (0 = accept cycle, -1 = never). Observes everything up to the response.
    task automatic run_req(input logic we, input logic [13:0] a, input logic [31:0] wd,
                           input int inv_at, output int lat, output logic hit,
                           output logic [31:0] rd, output int mcnt, output logic mwe,
                           output logic moe, output logic [13:0] maddr,
                           output logic [31:0] mwd);
        int  guard;
        bit  ok;
        guard = 0;
        ok    = 0;
        lat   = 0; hit = 0; rd = 0; mcnt = 0; mwe = 0; moe = 0; maddr = 0; mwd = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) chk("ready_timeout", 32'(req_ready), 32'h1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = wd;
        inv       = (inv_at == 0);
        @(negedge clk);
        req_valid = 1'b0;
        req_we    = 1'($urandom);
        req_addr  = 14'($urandom);
        req_wdata = $urandom;
        lat = 1;
        while (lat < 12) begin
            inv = (lat == inv_at);
            if (mem_cs) begin
                mcnt++;
                mwe = mem_we; moe = mem_oe; maddr = mem_addr; mwd = mem_wdata;
            end
            if (rsp_valid) begin
                ok  = 1;
                hit = rsp_hit;
                rd  = rsp_rdata;
                break;
            end
            @(negedge clk);
            lat++;
        end
        if (!ok) chk("rsp_timeout", 32'h0, 32'h1);
        @(negedge clk);
        inv = 1'b0;
        chk("rsp_pulse_ready", 32'({rsp_valid, req_ready}), 32'b01);
    endtask

    typedef struct {
        logic        rst;
        logic        we;
        logic [13:0] addr;
        logic [31:0] wd;
        int          inv_at;
        logic        e_hit;
        int          e_lat;
        logic [31:0] e_rd;
        logic [15:0] e_hc;
        logic [15:0] e_mc;
    } vec_t;

    vec_t tv [15];

    bit [15:0]   mv;
    logic [9:0]  mt [16];
    logic [31:0] md [16];
    logic [15:0] ehc, emc;
    logic [31:0] erd;

    initial begin
        int          lat, mcnt, elat, ulat, r, inv_at, quiet_bad;
        logic        hit, mwe, moe, we, mhit;
        logic [13:0] maddr, a;
        logic [31:0] rd, mwd, wd, fill;
        logic [3:0]  idx;

        #200000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat, mcnt, elat, ulat, r, inv_at, quiet_bad;
        logic        hit, mwe, moe, we, mhit;
        logic [13:0] maddr, a;
        logic [31:0] rd, mwd, wd, fill;
        logic [3:0]  idx;

        rst_n = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
        req_wdata = '0; inv = 1'b0;

        //              rst  we   addr     wdata         inv hit lat rdata                 hc  mc
        tv[0]  = '{1'b1, 1'b0, 14'h11E, 32'h0,        -1, 1'b0, 4, 32'h7800_0000,       0, 1};
        tv[1]  = '{1'b0, 1'b0, 14'h11E, 32'h0,        -1, 1'b1, 2, 32'h7800_0000,       1, 1};
        tv[2]  = '{1'b0, 1'b1, 14'h120, 32'h5,        -1, 1'b0, 3, 32'h7800_0000,       1, 1};
        tv[3]  = '{1'b0, 1'b0, 14'h120, 32'h0,        -1, 1'b1, 2, 32'h5,               2, 1};
        tv[4]  = '{1'b1, 1'b0, 14'h11E, 32'h0,        -1, 1'b0, 4, 32'h7800_0000,       0, 1};
        tv[5]  = '{1'b0, 1'b0, 14'h12E, 32'h0,        -1, 1'b0, 4, init_word(14'h12E),  0, 2};
        tv[6]  = '{1'b0, 1'b0, 14'h11E, 32'h0,        -1, 1'b0, 4, 32'h7800_0000,       0, 3};
        tv[7]  = '{1'b0, 1'b0, 14'h11E, 32'h0,         0, 1'b0, 4, 32'h7800_0000,       0, 4};
        tv[8]  = '{1'b1, 1'b0, 14'h100, 32'h0,        -1, 1'b0, 4, init_word(14'h100),  0, 1};
        tv[9]  = '{1'b0, 1'b0, 14'h102, 32'h0,        -1, 1'b0, 4, init_word(14'h102),  0, 2};
        tv[10] = '{1'b0, 1'b0, 14'h100, 32'h0,        -1, 1'b1, 2, init_word(14'h100),  1, 2};
        tv[11] = '{1'b0, 1'b0, 14'h102, 32'h0,        -1, 1'b1, 2, init_word(14'h102),  2, 2};
        tv[12] = '{1'b0, 1'b0, 14'h100, 32'h0,        -1, 1'b1, 2, init_word(14'h100),  3, 2};
        tv[13] = '{1'b0, 1'b1, 14'h102, 32'hDEAD_BEEF,-1, 1'b1, 3, init_word(14'h100),  3, 2};
        tv[14] = '{1'b0, 1'b0, 14'h102, 32'h0,        -1, 1'b1, 2, 32'hDEAD_BEEF,       4, 2};

        repeat (2) @(negedge clk);
        for (int i = 0; i < 15; i++) begin
            if (tv[i].rst) do_reset(i == 0);
            run_req(tv[i].we, tv[i].addr, tv[i].wd, tv[i].inv_at,
                    lat, hit, rd, mcnt, mwe, moe, maddr, mwd);
            chk($sformatf("t%0d_latency", i), 32'(lat), 32'(tv[i].e_lat));
            chk($sformatf("t%0d_hit", i), 32'(hit), 32'(tv[i].e_hit));
            chk($sformatf("t%0d_rdata", i), rd, tv[i].e_rd);
            chk($sformatf("t%0d_counters", i), {hit_cnt, miss_cnt}, {tv[i].e_hc, tv[i].e_mc});
            chk($sformatf("t%0d_mem_cmds", i), 32'(mcnt),
                (!tv[i].we && tv[i].e_hit) ? 32'd0 : 32'd1);
            if (mcnt != 0) begin
                chk($sformatf("t%0d_mem_we_oe", i), 32'({mwe, moe}), 32'({tv[i].we, !tv[i].we}));
                chk($sformatf("t%0d_mem_addr", i), 32'(maddr), 32'(tv[i].addr));
            end
            if (tv[i].we) begin
                if (mcnt != 0) chk($sformatf("t%0d_mem_wdata", i), mwd, tv[i].wd);
                chk($sformatf("t%0d_ram_word", i), ram_rd(tv[i].addr), tv[i].wd);
                mram[tv[i].addr] = tv[i].wd;
            end
        end

        // Reset while a miss sits in MEM_WAIT: drop the request, no response.
        do_reset(0);
        run_req(1'b0, 14'h11E, 32'h0, -1, lat, hit, rd, mcnt, mwe, moe, maddr, mwd);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 14'h104;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("midrst_mem_rd_cycle", 32'({mem_cs, mem_oe, mem_we}), 32'b110);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_ready_valid_hit", 32'({req_ready, rsp_valid, rsp_hit}), 32'b100);
        chk("midrst_mem_ctl", 32'({mem_cs, mem_we, mem_oe}), 32'b000);
        chk("midrst_mem_addr_wdata", 32'(mem_addr) | mem_wdata, 32'h0);
        chk("midrst_rdata", rsp_rdata, 32'h0);
        chk("midrst_counters", {hit_cnt, miss_cnt}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        quiet_bad = 0;
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid) quiet_bad++;
        end
        chk("midrst_no_response", 32'(quiet_bad), 32'h0);
        run_req(1'b0, 14'h104, 32'h0, -1, lat, hit, rd, mcnt, mwe, moe, maddr, mwd);
        chk("midrst_reload_hit", 32'(hit), 32'h0);
        chk("midrst_reload_rdata", rd, init_word(14'h104));
        chk("midrst_reload_miss_cnt", 32'(miss_cnt), 32'h1);

        // inv landing on the fill edge / store edge: response normal, line left invalid.
        run_req(1'b0, 14'h130, 32'h0, 3, lat, hit, rd, mcnt, mwe, moe, maddr, mwd);
        chk("invfill_lat", 32'(lat), 32'd4);
        chk("invfill_rdata", rd, init_word(14'h130));
        run_req(1'b0, 14'h130, 32'h0, -1, lat, hit, rd, mcnt, mwe, moe, maddr, mwd);
        chk("invfill_reload_hit_lat", 32'({hit, 4'(lat)}), 32'({1'b0, 4'd4}));
        run_req(1'b1, 14'h131, 32'h1234_5678, 2, lat, hit, rd, mcnt, mwe, moe, maddr, mwd);
        chk("invstore_lat", 32'(lat), 32'd3);
        mram[14'h131] = 32'h1234_5678;
        run_req(1'b0, 14'h131, 32'h0, -1, lat, hit, rd, mcnt, mwe, moe, maddr, mwd);
        chk("invstore_reload_hit", 32'(hit), 32'h0);
        chk("invstore_reload_rdata", rd, 32'h1234_5678);

        // Random traffic against a line-level model of the cache.
        do_reset(0);
        mv = '0; ehc = '0; emc = '0; erd = '0;
        for (int n = 0; n < 150; n++) begin
            we  = ($urandom_range(0, 3) == 0);
            a   = 14'h100 + 14'($urandom_range(0, 47));
            wd  = $urandom;
            r   = int'($urandom_range(0, 9));
            inv_at = (r < 7) ? -1 : r - 7;
            idx = a[3:0];
            if (inv_at == 0) mv = '0;
            mhit = mv[idx] && (mt[idx] == a[13:4]);
            if (!we) begin
                if (mhit) ehc = (ehc == 16'hFFFF) ? ehc : ehc + 16'd1;
                else      emc = (emc == 16'hFFFF) ? emc : emc + 16'd1;
                erd = mhit ? md[idx] : mram_rd(a);
            end
            fill = we ? wd : mram_rd(a);
            if (we) mram[a] = wd;
            ulat = we ? 2 : (mhit ? 0 : 3);
            elat = we ? 3 : (mhit ? 2 : 4);

            run_req(we, a, wd, inv_at, lat, hit, rd, mcnt, mwe, moe, maddr, mwd);

            if (inv_at >= 1 && ulat != 0 && inv_at < ulat) mv = '0;
            if (ulat != 0) begin
                mv[idx] = 1'b1; mt[idx] = a[13:4]; md[idx] = fill;
            end
            if (inv_at >= 1 && (ulat == 0 || inv_at >= ulat)) mv = '0;

            chk($sformatf("r%0d_lat", n), 32'(lat), 32'(elat));
            chk($sformatf("r%0d_hit", n), 32'(hit), 32'(mhit));
            chk($sformatf("r%0d_rdata", n), rd, erd);
            chk($sformatf("r%0d_counters", n), {hit_cnt, miss_cnt}, {ehc, emc});
            chk($sformatf("r%0d_mem_cmds", n), 32'(mcnt), (!we && mhit) ? 32'd0 : 32'd1);
            if (mcnt != 0) chk($sformatf("r%0d_mem_addr", n), 32'(maddr), 32'(a));
            if (we) chk($sformatf("r%0d_ram_word", n), ram_rd(a), wd);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
